// File: rtl/dec_pkg.sv
// MIPS32 decode constants, control bundle type and skid-buffer states
// shared by the decode stage and its per-lane decoder.
package dec_pkg;

  localparam int CTRL_W = 7;

  localparam logic [5:0] R_TYPE        = 6'h00;
  localparam logic [5:0] REGIMM        = 6'h01;
  localparam logic [5:0] J             = 6'h02;
  localparam logic [5:0] JAL           = 6'h03;
  localparam logic [5:0] BEQ           = 6'h04;
  localparam logic [5:0] BNE           = 6'h05;
  localparam logic [5:0] BLEZ          = 6'h06;
  localparam logic [5:0] BGTZ          = 6'h07;
  localparam logic [5:0] ADDI          = 6'h08;
  localparam logic [5:0] ADDIU         = 6'h09;
  localparam logic [5:0] SLTI          = 6'h0a;
  localparam logic [5:0] SLTIU         = 6'h0b;
  localparam logic [5:0] ANDI          = 6'h0c;
  localparam logic [5:0] ORI           = 6'h0d;
  localparam logic [5:0] XORI          = 6'h0e;
  localparam logic [5:0] LUI           = 6'h0f;
  localparam logic [5:0] COP0          = 6'h10;
  localparam logic [5:0] SPECIAL3_INST = 6'h1f;
  localparam logic [5:0] LB            = 6'h20;
  localparam logic [5:0] LH            = 6'h21;
  localparam logic [5:0] LW            = 6'h23;
  localparam logic [5:0] LBU           = 6'h24;
  localparam logic [5:0] LHU           = 6'h25;
  localparam logic [5:0] SB            = 6'h28;
  localparam logic [5:0] SH            = 6'h29;
  localparam logic [5:0] SW            = 6'h2b;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_BREAK   = 6'h0d;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1a;
  localparam logic [5:0] F_DIVU    = 6'h1b;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2a;
  localparam logic [5:0] F_SLTU    = 6'h2b;

  localparam logic [4:0] MFC0  = 5'h00;
  localparam logic [4:0] MTC0  = 5'h04;
  localparam logic [4:0] CO_RS = 5'h10;
  localparam logic [5:0] ERET  = 6'h18;

  typedef struct packed {
    logic regwrite;
    logic regdst;
    logic alusrc;
    logic branch;
    logic memtoreg;
    logic jump;
    logic memwrite;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } skid_st_e;

endpackage

// File: rtl/dec_lane.sv
// Combinational single-instruction MIPS32 decoder:
// control bundle, reserved-instruction flag, control-transfer flag.
module dec_lane
  import dec_pkg::*;
(
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              ri_o,
  output logic              cti_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic       is_r, is_st, is_ld, is_br;
  logic       is_j, is_imm, is_mfc0, is_mtc0;
  logic       is_eret, fn_ok, is_jr;
  ctrl_t      ctrl;
  logic       ri;

  assign op = instr_i[31:26];
  assign rs = instr_i[25:21];
  assign fn = instr_i[5:0];

  assign is_r   = op == R_TYPE;
  assign is_st  = op inside {SB, SH, SW};
  assign is_ld  = op inside {LB, LBU, LH, LHU, LW};
  assign is_br  = op inside {BEQ, BNE, BGTZ, BLEZ, REGIMM};
  assign is_j   = op inside {J, JAL};
  assign is_imm = op inside {ANDI, XORI, LUI, ORI,
                             ADDI, ADDIU, SLTI, SLTIU};

  assign is_mfc0 = op == COP0 && rs == MFC0;
  assign is_mtc0 = op == COP0 && rs == MTC0;
  assign is_eret = op == COP0 && rs == CO_RS && fn == ERET;

  assign fn_ok = fn inside {
    F_ADD, F_ADDU, F_SUB, F_SUBU, F_SLT, F_SLTU,
    F_AND, F_NOR, F_OR, F_XOR,
    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
    F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_JR, F_JALR,
    F_MULT, F_MULTU, F_DIV, F_DIVU,
    F_SYSCALL, F_BREAK};

  assign is_jr = is_r && fn inside {F_JR, F_JALR};

  always_comb begin
    ctrl = '0;
    ri   = 1'b0;
    unique case (1'b1)
      is_r: begin
        ri = !fn_ok;
        if (instr_i != '0) ctrl = ctrl_t'(7'b1100000);
      end
      is_st:   ctrl = ctrl_t'(7'b0010001);
      is_ld:   ctrl = ctrl_t'(7'b1010100);
      is_br:   ctrl = ctrl_t'(7'b0001000);
      is_j:    ctrl = ctrl_t'(7'b0000010);
      is_imm:  ctrl = ctrl_t'(7'b1010000);
      is_mfc0: ctrl = ctrl_t'(7'b1000000);
      is_mtc0, is_eret: ctrl = '0;
      default: ri = 1'b1;
    endcase
    if (ri) ctrl = '0;
  end

  assign ctrl_o = ctrl;
  assign ri_o   = ri;
  assign cti_o  = !ri && (ctrl.branch || ctrl.jump || is_jr);

endmodule

// File: rtl/decode_stage.sv
// Registered N-lane MIPS32 decode stage with 2-entry skid buffer.
// DECODE_PERF_CNT_EN adds transferred-lane and RI-lane counters.
module decode_stage
  import dec_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int PC_W    = 32
)(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ISSUE_W-1:0]         in_lane_vld,
  input  logic [32*ISSUE_W-1:0]      in_instr,
  input  logic [PC_W*ISSUE_W-1:0]    in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ISSUE_W-1:0]         out_lane_vld,
  output logic [32*ISSUE_W-1:0]      out_instr,
  output logic [PC_W*ISSUE_W-1:0]    out_pc,
  output logic [CTRL_W*ISSUE_W-1:0]  out_ctrl,
  output logic [ISSUE_W-1:0]         out_ri,
  output logic [ISSUE_W-1:0]         out_ds
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]                perf_inst_cnt,
  output logic [31:0]                perf_ri_cnt
`endif
);

  localparam int BW = ISSUE_W * (PC_W + 32 + CTRL_W + 3);

  skid_st_e state_q, state_d;
  logic [BW-1:0] out_q, skid_q, in_bus;
  logic          ds_pend_q, ds_pend_d;
  logic          accept;
  logic          ld_out_in, ld_out_skid, ld_skid;

  logic [ISSUE_W-1:0]        cti_w, ri_w, ds_w;
  logic [CTRL_W*ISSUE_W-1:0] ctrl_w;

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
    logic [CTRL_W-1:0] c;
    logic              r, t;
    dec_lane u_dec (
      .instr_i (in_instr[32*i+:32]),
      .ctrl_o  (c),
      .ri_o    (r),
      .cti_o   (t)
    );
    assign ctrl_w[CTRL_W*i+:CTRL_W] = in_lane_vld[i] ? c : '0;
    assign ri_w[i]  = in_lane_vld[i] & r;
    assign cti_w[i] = in_lane_vld[i] & t;
  end

  // Lane 0 inherits the slot from the previous bundle's youngest lane.
  always_comb begin
    ds_w    = '0;
    ds_w[0] = in_lane_vld[0] & ds_pend_q;
    for (int i = 1; i < ISSUE_W; i++)
      ds_w[i] = in_lane_vld[i] & cti_w[i-1];
  end

  always_comb begin
    ds_pend_d = ds_pend_q;
    for (int i = 0; i < ISSUE_W; i++)
      if (in_lane_vld[i]) ds_pend_d = cti_w[i];
  end

  assign in_bus = {in_lane_vld, in_instr, in_pc, ctrl_w, ri_w, ds_w};

  assign in_ready  = (state_q != ST_FULL2) && !flush;
  assign out_valid = state_q != ST_EMPTY;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FULL1;
        ST_FULL1: begin
          if (accept && !out_ready)      state_d = ST_FULL2;
          else if (!accept && out_ready) state_d = ST_EMPTY;
        end
        ST_FULL2: if (out_ready) state_d = ST_FULL1;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (!flush) begin
      unique case (state_q)
        ST_EMPTY: ld_out_in = accept;
        ST_FULL1: begin
          ld_out_in = accept && out_ready;
          ld_skid   = accept && !out_ready;
        end
        ST_FULL2: ld_out_skid = out_ready;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q     <= '0;
      skid_q    <= '0;
      ds_pend_q <= 1'b0;
    end else begin
      if (ld_out_in)        out_q <= in_bus;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid) skid_q <= in_bus;
      if (flush)       ds_pend_q <= 1'b0;
      else if (accept) ds_pend_q <= ds_pend_d;
    end
  end

  assign {out_lane_vld, out_instr, out_pc,
          out_ctrl, out_ri, out_ds} = out_q;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] inst_cnt_q, ri_cnt_q;
  logic [31:0] n_inst, n_ri;

  always_comb begin
    n_inst = '0;
    n_ri   = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      n_inst = n_inst + 32'(out_lane_vld[i]);
      n_ri   = n_ri + 32'(out_ri[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_cnt_q <= '0;
      ri_cnt_q   <= '0;
    end else if (out_valid && out_ready && !flush) begin
      inst_cnt_q <= inst_cnt_q + n_inst;
      ri_cnt_q   <= ri_cnt_q + n_ri;
    end
  end

  assign perf_inst_cnt = inst_cnt_q;
  assign perf_ri_cnt   = ri_cnt_q;
`endif

endmodule
